// File: rtl/game_state_fsm_if.sv
// Signal bundle between the game sequencer and the rest of the game top level:
// frame strobe, keyboard and collision flags in; revive/play gating and HEX data out.
interface game_state_fsm_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       gameover;
    logic       gamewin;
    logic       revive;
    logic       play_en;
    logic [1:0] game_state;
    logic [7:0] elapsed_sec;

    modport master (
        output frame_clk, keycode, gameover, gamewin,
        input  revive, play_en, game_state, elapsed_sec
    );

    modport slave (
        input  frame_clk, keycode, gameover, gamewin,
        output revive, play_en, game_state, elapsed_sec
    );
endinterface

// File: rtl/game_state_fsm.sv
// Game sequencer: TITLE/PLAY/OVER/WIN control, revive pulse and per-level seconds timer.
// Build option: define FSM_AUTO_RESTART_EN to restart from OVER without a key once the dwell completes.
module game_state_fsm #(
    parameter int         FRAMES_PER_SEC = 60,
    parameter logic [7:0] START_KEY      = 8'h28,
    parameter int         RESTART_FRAMES = 120
) (
    input  logic            Clk,
    input  logic            Reset_n,
    game_state_fsm_if.slave gs
);
    localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int DW_W = (RESTART_FRAMES > 0) ? $clog2(RESTART_FRAMES + 1) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);
    localparam logic [DW_W-1:0] DW_DONE = DW_W'(RESTART_FRAMES);

    typedef enum logic [1:0] {
        TITLE = 2'b00,
        PLAY  = 2'b01,
        OVER  = 2'b10,
        WIN   = 2'b11
    } state_t;

    state_t          state, state_next;
    logic            sync_p0, sync_p1, sync_p2, tick_p3;
    logic [7:0]      key_prev;
    logic            start_press;
    logic            restart;
    logic            dwell_done;
    logic [FC_W-1:0] frame_cnt, frame_cnt_next;
    logic [7:0]      sec_cnt, sec_cnt_next;
    logic [DW_W-1:0] dwell_cnt, dwell_cnt_next;
    logic            revive_q, revive_next;
    logic            play_en_q;

    function automatic logic [7:0] sat_inc_sec(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [DW_W-1:0] sat_inc_dwell(input logic [DW_W-1:0] v);
        return (v == DW_DONE) ? v : v + 1'b1;
    endfunction

    // Stage p0..p2: frame strobe synchroniser; p3: registered one-Clk rising-edge tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            sync_p2  <= 1'b0;
            tick_p3  <= 1'b0;
            key_prev <= 8'h00;
        end else begin
            sync_p0  <= gs.frame_clk;
            sync_p1  <= sync_p0;
            sync_p2  <= sync_p1;
            tick_p3  <= sync_p1 & ~sync_p2;
            key_prev <= gs.keycode;
        end
    end

    assign start_press = (gs.keycode == START_KEY) && (key_prev != START_KEY);
    assign dwell_done  = (dwell_cnt == DW_DONE);

    always_comb begin
        state_next     = state;
        revive_next    = 1'b0;
        restart        = 1'b0;
        frame_cnt_next = frame_cnt;
        sec_cnt_next   = sec_cnt;
        dwell_cnt_next = dwell_cnt;
        unique case (state)
            TITLE: restart = start_press;
            PLAY: begin
                if (tick_p3) begin
                    if (frame_cnt == FC_LAST) begin
                        frame_cnt_next = '0;
                        sec_cnt_next   = sat_inc_sec(sec_cnt);
                    end else begin
                        frame_cnt_next = frame_cnt + 1'b1;
                    end
                end
                // A death outranks a simultaneous win
                if (gs.gameover) begin
                    state_next     = OVER;
                    dwell_cnt_next = '0;
                end else if (gs.gamewin) begin
                    state_next     = WIN;
                    dwell_cnt_next = '0;
                end
            end
            OVER: begin
`ifdef FSM_AUTO_RESTART_EN
                restart = dwell_done;
`else
                restart = dwell_done && start_press;
`endif
            end
            WIN: restart = dwell_done && start_press;
            default: ;
        endcase

        if (restart) begin
            state_next     = PLAY;
            revive_next    = 1'b1;
            frame_cnt_next = '0;
            sec_cnt_next   = 8'h00;
        end else if (((state == OVER) || (state == WIN)) && tick_p3) begin
            dwell_cnt_next = sat_inc_dwell(dwell_cnt);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= TITLE;
            frame_cnt <= '0;
            sec_cnt   <= 8'h00;
            dwell_cnt <= '0;
            revive_q  <= 1'b0;
            play_en_q <= 1'b0;
        end else begin
            state     <= state_next;
            frame_cnt <= frame_cnt_next;
            sec_cnt   <= sec_cnt_next;
            dwell_cnt <= dwell_cnt_next;
            revive_q  <= revive_next;
            play_en_q <= (state_next == PLAY);
        end
    end

    assign gs.game_state  = state;
    assign gs.revive      = revive_q;
    assign gs.play_en     = play_en_q;
    assign gs.elapsed_sec = sec_cnt;
endmodule

// File: tb/tb_game_state_fsm.sv
// Bench for game_state_fsm: tick-counting reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_game_state_fsm;
    localparam int         FPS       = 60;
    localparam logic [7:0] START_KEY = 8'h28;
    localparam int         RF        = 120;
`ifdef FSM_AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset_n = 1'b1;

    game_state_fsm_if bus();

    game_state_fsm #(
        .FRAMES_PER_SEC(FPS),
        .START_KEY     (START_KEY),
        .RESTART_FRAMES(RF)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .gs     (bus)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;
    int rev_cnt = 0;

    // Reference model: state as spec encoding, time measured in frame ticks
    int         m_state = 0;
    int         m_play_ticks = 0;
    int         m_dwell_ticks = 0;
    bit         m_revive = 1'b0;
    bit         fc_h [4] = '{default: 1'b0};
    logic [7:0] m_prev_key = 8'h00;
    bit         m_tick, m_press, m_restart;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_elapsed(input int ticks);
        return (ticks / FPS > 255) ? 255 : ticks / FPS;
    endfunction

    initial begin
        forever begin
            @(posedge Clk or negedge Reset_n);
            if (!Reset_n) begin
                m_state       = 0;
                m_play_ticks  = 0;
                m_dwell_ticks = 0;
                m_revive      = 1'b0;
                fc_h          = '{default: 1'b0};
                m_prev_key    = 8'h00;
            end else begin
                // fc_h[k] holds frame_clk as sampled k+1 edges ago
                m_tick    = fc_h[2] && !fc_h[3];
                m_press   = (bus.keycode == START_KEY) && (m_prev_key != START_KEY);
                m_restart = 1'b0;
                m_revive  = 1'b0;
                case (m_state)
                    0: m_restart = m_press;
                    1: begin
                        if (m_tick) m_play_ticks++;
                        if (bus.gameover) begin
                            m_state = 2;
                            m_dwell_ticks = 0;
                        end else if (bus.gamewin) begin
                            m_state = 3;
                            m_dwell_ticks = 0;
                        end
                    end
                    default: begin
                        m_restart = (m_dwell_ticks >= RF) &&
                                    (m_press || (AUTO && m_state == 2));
                        if (!m_restart && m_tick) m_dwell_ticks++;
                    end
                endcase
                if (m_restart) begin
                    m_state      = 1;
                    m_revive     = 1'b1;
                    m_play_ticks = 0;
                end
                fc_h[3]    = fc_h[2];
                fc_h[2]    = fc_h[1];
                fc_h[1]    = fc_h[0];
                fc_h[0]    = bus.frame_clk;
                m_prev_key = bus.keycode;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            check("state",   int'(bus.game_state),  m_state);
            check("play_en", int'(bus.play_en),     int'(m_state == 1));
            check("revive",  int'(bus.revive),      int'(m_revive));
            check("elapsed", int'(bus.elapsed_sec), exp_elapsed(m_play_ticks));
            if (bus.revive === 1'b1) rev_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frames(input int n, input int half);
        repeat (n) begin
            bus.frame_clk = 1'b1;
            cyc(half);
            bus.frame_clk = 1'b0;
            cyc(half);
        end
    endtask

    task automatic press_key();
        bus.keycode = START_KEY;
        cyc(3);
        bus.keycode = 8'h00;
        cyc(2);
    endtask

    initial begin
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'h00;
        bus.gameover  = 1'b0;
        bus.gamewin   = 1'b0;
        #2 Reset_n = 1'b0;
        cyc(3);
        check("rst_state",   int'(bus.game_state),  0);
        check("rst_play_en", int'(bus.play_en),     0);
        check("rst_revive",  int'(bus.revive),      0);
        check("rst_elapsed", int'(bus.elapsed_sec), 0);
        Reset_n = 1'b1;
        cyc(2);

        // Collision flags mean nothing in TITLE
        bus.gameover = 1'b1;
        bus.gamewin  = 1'b1;
        cyc(2);
        bus.gameover = 1'b0;
        bus.gamewin  = 1'b0;
        cyc(1);
        check("title_ignores_flags", int'(bus.game_state), 0);

        // Held start key gives a single revive
        rev_cnt = 0;
        bus.keycode = START_KEY;
        cyc(50);
        bus.keycode = 8'h00;
        cyc(2);
        check("start_revive_count", rev_cnt, 1);
        check("start_state",        int'(bus.game_state), 1);
        check("start_play_en",      int'(bus.play_en), 1);

        frames(61, 2);
        cyc(5);
        check("one_second", int'(bus.elapsed_sec), 1);

        frames(15400, 1);
        cyc(5);
        check("elapsed_saturates", int'(bus.elapsed_sec), 255);

        bus.gameover = 1'b1;
        bus.gamewin  = 1'b1;
        cyc(1);
        bus.gameover = 1'b0;
        bus.gamewin  = 1'b0;
        check("both_flags_over", int'(bus.game_state), 2);
        check("over_play_en",    int'(bus.play_en), 0);

`ifndef FSM_AUTO_RESTART_EN
        rev_cnt = 0;
        frames(50, 2);
        press_key();
        check("early_press_state",  int'(bus.game_state), 2);
        check("early_press_revive", rev_cnt, 0);
        frames(71, 2);
        cyc(3);
        rev_cnt = 0;
        press_key();
        check("restart_revive",  rev_cnt, 1);
        check("restart_state",   int'(bus.game_state), 1);
        check("restart_elapsed", int'(bus.elapsed_sec), 0);
`else
        rev_cnt = 0;
        frames(125, 2);
        cyc(4);
        check("auto_restart_revive", rev_cnt, 1);
        check("auto_restart_state",  int'(bus.game_state), 1);
        check("auto_restart_elapsed", int'(bus.elapsed_sec), 0);
`endif

        // WIN never leaves without a key
        bus.gamewin = 1'b1;
        cyc(1);
        bus.gamewin = 1'b0;
        frames(130, 2);
        cyc(4);
        check("win_holds", int'(bus.game_state), 3);
        press_key();
        check("win_restart", int'(bus.game_state), 1);

        // Reset in the middle of a level
        frames(70, 2);
        cyc(2);
        rev_cnt = 0;
        #2 Reset_n = 1'b0;
        #1;
        check("midrst_state",   int'(bus.game_state),  0);
        check("midrst_play_en", int'(bus.play_en),     0);
        check("midrst_elapsed", int'(bus.elapsed_sec), 0);
        cyc(3);
        Reset_n = 1'b1;
        cyc(5);
        check("midrst_no_revive", rev_cnt, 0);
        check("midrst_title",     int'(bus.game_state), 0);

        // Randomized soak against the model
        for (int i = 0; i < 20000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 6)       bus.keycode = START_KEY;
            else if (r < 14) bus.keycode = 8'h00;
            else if (r < 16) bus.keycode = 8'($urandom_range(1, 255));
            bus.frame_clk = 1'($urandom_range(0, 1));
            bus.gameover  = ($urandom_range(0, 1499) == 0);
            bus.gamewin   = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end
        bus.gameover = 1'b0;
        bus.gamewin  = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
